count_bcd_display: RTL and testbench

Downstream display stage for the 9-bit enabled counter: samples the `count` bus, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed 3-digit seven-segment display. It connects directly to the counter's `count` output on the same clock and gives a human-readable view of the counter on the board.

---
 rtl/count_bcd_display.sv | 137 +++++++++++++
 tb/tb_count_bcd_display.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
// Display stage for the 9-bit counter: sequential double-dabble BCD conversion
// feeding a time-multiplexed 3-digit seven-segment driver with leading-zero blanking.
module count_bcd_display #(
   parameter int REFRESH_DIV = 1000,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  count,
   output logic [11:0] bcd,
   output logic        bcd_valid,
   output logic [6:0]  seg,
   output logic [2:0]  digit_en
);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   localparam int         CW      = $clog2(REFRESH_DIV);
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7f : 7'h00;
   localparam logic [2:0] DEN_OFF = ACTIVE_LOW ? 3'b111 : 3'b000;

   state_t        state, state_next;
   logic [8:0]    shift_reg, shift_next;
   logic [11:0]   scratch, scratch_next;
   logic [11:0]   adjusted;
   logic [3:0]    iter, iter_next;
   logic [11:0]   bcd_next;
   logic          bcd_valid_next;

   logic [CW-1:0] refresh_cnt;
   logic          wrap;
   logic [1:0]    idx, idx_next;
   logic [3:0]    digit;
   logic [6:0]    seg_raw;
   logic [2:0]    den_raw;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'h3f;
         4'd1:    encode = 7'h06;
         4'd2:    encode = 7'h5b;
         4'd3:    encode = 7'h4f;
         4'd4:    encode = 7'h66;
         4'd5:    encode = 7'h6d;
         4'd6:    encode = 7'h7d;
         4'd7:    encode = 7'h07;
         4'd8:    encode = 7'h7f;
         4'd9:    encode = 7'h6f;
         default: encode = 7'h00;
      endcase
   endfunction

   // Converter next-state and datapath.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
      state_next     = state;
      shift_next     = shift_reg;
      scratch_next   = scratch;
      iter_next      = iter;
      bcd_next       = bcd;
      bcd_valid_next = 1'b0;
      adjusted       = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
      unique case (state)
         IDLE: begin
            shift_next   = count;
            scratch_next = '0;
            iter_next    = '0;
            state_next   = CONV;
         end
         CONV: begin
            {scratch_next, shift_next} = {adjusted, shift_reg} << 1;
            iter_next = iter + 4'd1;
            if (iter == 4'd8) state_next = LOAD;
         end
         LOAD: begin
            bcd_next       = scratch;
            bcd_valid_next = 1'b1;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         scratch   <= '0;
         iter      <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         scratch   <= scratch_next;
         iter      <= iter_next;
         bcd       <= bcd_next;
         bcd_valid <= bcd_valid_next;
      end
   end

   // Display mux: select, encode and blank the digit that becomes active next cycle.
   always_comb begin
      wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
      idx_next = idx;
      if (wrap) idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      case (idx_next)
         2'd1:    begin digit = bcd[7:4];  den_raw = 3'b010; end
         2'd2:    begin digit = bcd[11:8]; den_raw = 3'b100; end
         default: begin digit = bcd[3:0];  den_raw = 3'b001; end
      endcase
      seg_raw = encode(digit);
      if ((idx_next == 2'd2 && bcd[11:8] == 4'd0) ||
          (idx_next == 2'd1 && bcd[11:4] == 8'd0))
         seg_raw = 7'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt <= '0;
         idx         <= 2'd0;
         seg         <= SEG_OFF;
         digit_en    <= DEN_OFF;
      end else begin
         refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
         idx         <= idx_next;
         seg         <= ACTIVE_LOW ? ~seg_raw : seg_raw;
         digit_en    <= ACTIVE_LOW ? ~den_raw : den_raw;
      end
   end

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display: one active-high and one active-low
// instance (REFRESH_DIV=4) driven from a shared clock and reset.
module tb_count_bcd_display;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  count_a, count_n;
   logic [11:0] bcd_a, bcd_n;
   logic        valid_a, valid_n;
   logic [6:0]  seg_a, seg_n;
   logic [2:0]  den_a, den_n;

   int total  = 0;
   int bad    = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   count_bcd_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .reset(reset), .count(count_a), .bcd(bcd_a),
      .bcd_valid(valid_a), .seg(seg_a), .digit_en(den_a)
   );

   count_bcd_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .reset(reset), .count(count_n), .bcd(bcd_n),
      .bcd_valid(valid_n), .seg(seg_n), .digit_en(den_n)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic step_to(input int e);
      while (edge_n < e) step();
   endtask

   task automatic reset_cycles(input string tag);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check({tag, "_seg"},   seg_a,   16'h00);
         check({tag, "_den"},   den_a,   16'h0);
         check({tag, "_bcd"},   bcd_a,   16'h000);
         check({tag, "_valid"}, valid_a, 16'h0);
         check({tag, "_seg_n"}, seg_n,   16'h7f);
         check({tag, "_den_n"}, den_n,   16'h7);
      end
      reset  = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      reset   = 1'b1;
      count_a = 9'd0;
      count_n = 9'd8;

      // Reset, then zero: ones lit, tens/hundreds blanked.
      reset_cycles("rst");
      step();
      check("first_den",   den_a, 16'h1);
      check("first_seg",   seg_a, 16'h3f);
      check("first_den_n", den_n, 16'h6);
      check("first_seg_n", seg_n, 16'h40);
      step_to(3);
      check("zero_ones_hold", den_a, 16'h1);
      step_to(4);
      check("zero_tens_den",   den_a, 16'h2);
      check("zero_tens_blank", seg_a, 16'h00);
      check("pol_tens_den",    den_n, 16'h5);
      check("pol_tens_blank",  seg_n, 16'h7f);
      step_to(8);
      check("zero_hund_den",   den_a, 16'h4);
      check("zero_hund_blank", seg_a, 16'h00);
      check("pol_hund_den",    den_n, 16'h3);
      step_to(10);
      check("zero_valid_early", valid_a, 16'h0);
      step_to(11);
      check("zero_valid", valid_a, 16'h1);
      check("zero_bcd",   bcd_a,   16'h000);
      check("pol_valid",  valid_n, 16'h1);
      check("pol_bcd",    bcd_n,   16'h008);
      count_a = 9'd511;
      step_to(12);
      check("valid_pulse_width", valid_a, 16'h0);
      check("zero_ones_seg",     seg_a,   16'h3f);
      check("pol_ones_seg",      seg_n,   16'h00);
      check("pol_ones_den",      den_n,   16'h6);
      step_to(16);
      check("pol_tens_den2",   den_n, 16'h5);
      check("pol_tens_blank2", seg_n, 16'h7f);
      step_to(20);
      check("pol_hund_den2",   den_n, 16'h3);
      check("pol_hund_blank2", seg_n, 16'h7f);

      // Maximum: sampled at edge 12, result at edge 22.
      step_to(21);
      check("max_valid_early", valid_a, 16'h0);
      step_to(22);
      check("max_valid", valid_a, 16'h1);
      check("max_bcd",   bcd_a,   16'h511);
      step_to(23);
      check("max_hund_den", den_a, 16'h4);
      check("max_hund_seg", seg_a, 16'h6d);
      step_to(24);
      check("max_ones_den", den_a, 16'h1);
      check("max_ones_seg", seg_a, 16'h06);
      step_to(28);
      check("max_tens_den", den_a, 16'h2);
      check("max_tens_seg", seg_a, 16'h06);

      // Inner zero: 305 sampled at edge 34, input changes to 7 mid-conversion.
      count_a = 9'd305;
      step_to(35);
      count_a = 9'd7;
      step_to(44);
      check("inner_valid", valid_a, 16'h1);
      check("inner_bcd",   bcd_a,   16'h305);
      step_to(45);
      check("inner_hund_seg", seg_a, 16'h4f);
      step_to(48);
      check("inner_ones_seg", seg_a, 16'h6d);
      step_to(52);
      check("inner_tens_den", den_a, 16'h2);
      check("inner_tens_seg", seg_a, 16'h3f);
      step_to(55);
      check("seven_valid", valid_a, 16'h1);
      check("seven_bcd",   bcd_a,   16'h007);
      step_to(56);
      check("seven_hund_blank", seg_a, 16'h00);
      step_to(60);
      check("seven_ones_seg", seg_a, 16'h07);
      step_to(64);
      check("seven_tens_blank", seg_a, 16'h00);

      // Refresh rotation with 123 after a fresh reset.
      count_a = 9'd123;
      reset_cycles("rst2");
      for (int e = 1; e <= 20; e++) begin
         logic [2:0] want;
         step();
         if (e < 4) want = 3'b001;
         else case (((e - 4) / 4) % 3)
            0:       want = 3'b010;
            1:       want = 3'b100;
            default: want = 3'b001;
         endcase
         check("rot_den", den_a, 16'(want));
         if (e == 11) check("rot_bcd", bcd_a, 16'h123);
         if (e == 12) check("rot_ones_seg", seg_a, 16'h4f);
         if (e == 16) check("rot_tens_seg", seg_a, 16'h5b);
         if (e == 20) check("rot_hund_seg", seg_a, 16'h06);
      end

      // Reset during CONV discards the partial result.
      reset_cycles("rst3");
      step_to(5);
      reset_cycles("abort");
      for (int e = 1; e <= 10; e++) begin
         step();
         check("abort_no_valid", valid_a, 16'h0);
         check("abort_bcd_held", bcd_a,   16'h000);
      end
      step();
      check("abort_recover_valid", valid_a, 16'h1);
      check("abort_recover_bcd",   bcd_a,   16'h123);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
